// File: rtl/varredura_matriz_if.sv
// Bus between the attack manager, the 5x7 LED scan driver and the matrix pins.
// The master supplies revealed cells and cursor; the slave drives the pins.
interface varredura_matriz_if;
  logic [6:0] matriz0;
  logic [6:0] matriz1;
  logic [6:0] matriz2;
  logic [6:0] matriz3;
  logic [6:0] matriz4;
  logic [2:0] coordColuna;
  logic [2:0] coordLinha;
  logic       enable;
  logic [4:0] colunas;
  logic [6:0] linhas;
  logic       fim_quadro;

  modport master (
    output matriz0, matriz1, matriz2, matriz3, matriz4,
    output coordColuna, coordLinha, enable,
    input  colunas, linhas, fim_quadro
  );

  modport slave (
    input  matriz0, matriz1, matriz2, matriz3, matriz4,
    input  coordColuna, coordLinha, enable,
    output colunas, linhas, fim_quadro
  );
endinterface

// File: rtl/varredura_matriz.sv
// Column-multiplexed scan driver for a 5x7 LED matrix with a one-cycle blank
// between columns and a frame-rate blinking cursor overlay.
module varredura_matriz #(
  parameter int DIV_VARREDURA = 50000,
  parameter int PISCA_QUADROS = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  varredura_matriz_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_VARREDURA);
  localparam int QDR_W = (PISCA_QUADROS > 1) ? $clog2(PISCA_QUADROS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_VARREDURA - 1);
  localparam logic [QDR_W-1:0] QDR_MAX = QDR_W'(PISCA_QUADROS - 1);

  generate
    if (DIV_VARREDURA < 2) begin : g_div_invalido
      $error("DIV_VARREDURA must be at least 2");
    end
    if (PISCA_QUADROS < 1) begin : g_pisca_invalido
      $error("PISCA_QUADROS must be at least 1");
    end
  endgenerate

  logic [CNT_W-1:0] contador_q, contador_d;
  logic [2:0]       coluna_q, coluna_d;
  logic [QDR_W-1:0] quadros_q, quadros_d;
  logic             pisca_q, pisca_d;
  logic [4:0]       colunas_q, colunas_d;
  logic [6:0]       linhas_q, linhas_d;
  logic             fim_quadro_q, fim_quadro_d;

  logic [6:0] dados_coluna;
  logic       cursor_ativo;
  logic [6:0] linhas_snap;
  logic [4:0] colunas_snap;

  always_comb begin
    dados_coluna = '0;
    case (coluna_q)
      3'd0:    dados_coluna = bus.matriz0;
      3'd1:    dados_coluna = bus.matriz1;
      3'd2:    dados_coluna = bus.matriz2;
      3'd3:    dados_coluna = bus.matriz3;
      3'd4:    dados_coluna = bus.matriz4;
      default: dados_coluna = '0;
    endcase
  end

  // Out-of-range column never matches coluna_q; row 7 is excluded explicitly.
  assign cursor_ativo = bus.enable && (bus.coordColuna == coluna_q) &&
                        (bus.coordLinha != 3'd7);

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_linha
      assign linhas_snap[gi] = (cursor_ativo && (bus.coordLinha == 3'(gi))) ?
                               pisca_q : dados_coluna[gi];
    end
    for (gi = 0; gi < 5; gi++) begin : g_coluna
      assign colunas_snap[gi] = (coluna_q != 3'(gi));
    end
  endgenerate

  // The output registers themselves hold the per-slot snapshot.
  always_comb begin
    contador_d   = contador_q;
    coluna_d     = coluna_q;
    quadros_d    = quadros_q;
    pisca_d      = pisca_q;
    colunas_d    = colunas_q;
    linhas_d     = linhas_q;
    fim_quadro_d = 1'b0;

    if (contador_q == CNT_MAX) begin
      contador_d = '0;
      colunas_d  = 5'b11111;
      linhas_d   = '0;
      if (coluna_q == 3'd4) begin
        coluna_d     = 3'd0;
        fim_quadro_d = 1'b1;
        if (quadros_q == QDR_MAX) begin
          quadros_d = '0;
          pisca_d   = ~pisca_q;
        end else begin
          quadros_d = quadros_q + 1'b1;
        end
      end else begin
        coluna_d = coluna_q + 3'd1;
      end
    end else begin
      contador_d = contador_q + 1'b1;
      if (contador_q == '0) begin
        colunas_d = colunas_snap;
        linhas_d  = linhas_snap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_q   <= '0;
      coluna_q     <= 3'd0;
      quadros_q    <= '0;
      pisca_q      <= 1'b0;
      colunas_q    <= 5'b11111;
      linhas_q     <= '0;
      fim_quadro_q <= 1'b0;
    end else begin
      contador_q   <= contador_d;
      coluna_q     <= coluna_d;
      quadros_q    <= quadros_d;
      pisca_q      <= pisca_d;
      colunas_q    <= colunas_d;
      linhas_q     <= linhas_d;
      fim_quadro_q <= fim_quadro_d;
    end
  end

  assign bus.colunas    = colunas_q;
  assign bus.linhas     = linhas_q;
  assign bus.fim_quadro = fim_quadro_q;

endmodule

// File: doc/varredura_matriz.md
# varredura_matriz

Multiplexed scan driver for the 5-column × 7-row LED matrix. It sits directly downstream of the attack manager and consumes its revealed-cell vectors `matriz0`..`matriz4`. It time-multiplexes one column at a time onto the physical column/row pins, inserting a one-cycle blanking gap between columns. It also overlays a blinking cursor at the currently selected attack coordinate.

## Interface

Parameters:
- `DIV_VARREDURA`, default 50000: clock cycles per column slot; must be ≥ 2.
- `PISCA_QUADROS`, default 50: number of full frames per cursor blink toggle; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `matriz0`..`matriz4`  in  7 each  revealed cells per column; bit `i` = row `i`; 1 = LED lit.
- `coordColuna`  in  3  cursor column, 0..4 valid.
- `coordLinha`  in  3  cursor row, 0..6 valid.
- `enable`  in  1  cursor overlay enable.
- `colunas`  out  5  column select, one-hot, active-low; bit `c` = column `c`.
- `linhas`  out  7  row data, active-high.
- `fim_quadro`  out  1  one-cycle pulse at the end of the column-4 slot.

## Operation

- State:
  - `contador`, range 0..DIV_VARREDURA-1.
  - `coluna`, range 0..4.
  - `quadros`, range 0..PISCA_QUADROS-1.
  - `pisca`, 1 bit.
  - Registered outputs.
- Slot cycle per column `c`:
  - **BLANK** (`contador`==0, 1 cycle): `colunas`=5'b11111, `linhas`=0.
  - **DRIVE** (`contador` 1..DIV_VARREDURA-1): `colunas` has only bit `c` low; `linhas` holds the snapshot taken for this slot.
- Snapshot: taken on the edge where `contador` goes 0→1. The snapshot captures `matriz<c>`, `coordColuna`, `coordLinha`, `enable` and `pisca`. Input changes during DRIVE have no effect until the next slot.
- Cursor: applies when snapshot `enable`=1, `coordColuna`==`c`, and `coordLinha`≤6. Row bit `coordLinha` is then forced to `pisca`; all other bits come from `matriz<c>`. If `coordColuna`>4 or `coordLinha`==7, no cursor is shown.
- Advance: on the edge where `contador`==DIV_VARREDURA-1:
  - `contador`→0.
  - `coluna` increments, wrapping 4→0.
- Frame end: when that advance edge occurs with `coluna`==4:
  - `fim_quadro`=1 for the next cycle.
  - `quadros` increments.
  - When `quadros`==PISCA_QUADROS-1, `quadros` wraps to 0 and `pisca` toggles.
- Column order is fixed: 0,1,2,3,4,0,…

## Timing

- Reset (async assert, any time): `colunas`=5'b11111, `linhas`=0, `fim_quadro`=0, `contador`=0, `coluna`=0, `quadros`=0, `pisca`=0.
- Outputs stay in the blanked reset state while `rst_n`=0.
- First rising edge after release:
  - `contador` goes 0→1, so column 0 DRIVE begins.
  - Outputs show column 0 data.
  - The cycle before that edge is the BLANK of slot 0.
- Slot length is DIV_VARREDURA cycles: 1 BLANK + (DIV_VARREDURA-1) DRIVE.
- Frame length is 5·DIV_VARREDURA cycles.
- Cursor toggle period is PISCA_QUADROS·5·DIV_VARREDURA cycles.
- `fim_quadro` is high exactly during the BLANK cycle of column 0 that follows the column-4 slot. It never asserts during the first slot after reset.
- At most one `colunas` bit is low at any time. No cycle drives two columns.
- Reset mid-slot or mid-frame: immediate blanking. The scan restarts at column 0 with `pisca`=0, and no `fim_quadro` pulse is emitted.
- Simultaneous frame-end and blink wrap: `fim_quadro` and the `pisca` toggle become visible on the same edge. The new `pisca` value is used by the next column-0 snapshot.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with random inputs → `colunas`=11111, `linhas`=0, `fim_quadro`=0. On release, the first edge gives `colunas`=11110.
- **Scan order:** DIV_VARREDURA=4, all `matriz`=7'h7F, `enable`=0 → `colunas` repeats 11111,11110×3, 11111,11101×3, …, 01111×3. `linhas`=7'h7F during DRIVE. `fim_quadro` pulses once per 20 cycles.
- **Pixel mapping:** `matriz2`=7'b0100000, others 0 → `linhas`=7'b0100000 only while `colunas`=11011. `linhas` is 0 in every other slot.
- **Cursor blink:** DIV_VARREDURA=4, PISCA_QUADROS=2, all `matriz`=0, `enable`=1, `coordColuna`=1, `coordLinha`=3:
  - `linhas`=0 in column 1 for frames 0–1.
  - `linhas`=7'b0001000 in column 1 for frames 2–3.
  - The pattern then alternates.
  - Repeat with `coordLinha`=7 or `coordColuna`=5 → `linhas` stays 0.
- **Snapshot stability:** change `matriz0` from 0 to 7'h7F two cycles into the column-0 DRIVE → `linhas` stays 0 until the next column-0 slot, which then shows 7'h7F.
- **Reset mid-frame:** assert `rst_n`=0 during the column-3 DRIVE → outputs blank immediately. After release the scan resumes at column 0 with `pisca`=0.
